union_find_pc: RTL

Parametrised disjoint-set (union-find) engine. Successor to the basic union/find block, adding union-by-rank, two-pass path compression, a same-set query, a bulk clear, live set counting and range checking. Used by the connected-component labelling stage in the algorithm path to merge provisional labels. It is a single-request command engine: start/busy/done handshake, with parent and rank arrays held in registers.

---
 rtl/union_find_pc.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/union_find_pc.sv
// rtl/union_find_pc.sv - disjoint-set engine with union-by-rank, path compression and set counting
module union_find_pc #(
   parameter int N          = 16,
   parameter int ADDR_WIDTH = 4,
   parameter int RANK_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic [ADDR_WIDTH-1:0] node1,
   input  logic [ADDR_WIDTH-1:0] node2,
   output logic [ADDR_WIDTH-1:0] result,
   output logic                  same_set,
   output logic                  merged,
   output logic                  error,
   output logic [ADDR_WIDTH:0]   set_count,
   output logic                  busy,
   output logic                  done
);
   localparam logic [1:0] OP_FIND  = 2'b00;
   localparam logic [1:0] OP_UNION = 2'b01;
   localparam logic [1:0] OP_SAME  = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N - 1);
   localparam logic [ADDR_WIDTH:0]   N_SETS   = (ADDR_WIDTH + 1)'(N);
   localparam logic [RANK_WIDTH-1:0] RANK_MAX = '1;

   typedef enum logic [2:0] {
      S_INIT, S_IDLE, S_FIND_A, S_COMP_A, S_FIND_B, S_COMP_B, S_LINK, S_DONE
   } state_t;

   state_t state, state_nxt;

   logic [ADDR_WIDTH-1:0] parent [N];
   logic [RANK_WIDTH-1:0] rank   [N];

   logic [1:0]            op_q;
   logic [ADDR_WIDTH-1:0] n1_q, n2_q, cur, root_a, root_b, idx;
   logic                  clr_pend;

   logic [ADDR_WIDTH-1:0] cur_par;
   logic [RANK_WIDTH-1:0] rank_a, rank_b;
   logic                  roots_eq, uses_b, bad1, bad2, op_err;

   assign cur_par  = parent[cur];
   assign rank_a   = rank[root_a];
   assign rank_b   = rank[root_b];
   assign roots_eq = (root_a == root_b);
   assign uses_b   = (op == OP_UNION) || (op == OP_SAME);
   assign bad1     = ({1'b0, node1} >= N_SETS);
   assign bad2     = ({1'b0, node2} >= N_SETS);
   assign op_err   = (op != OP_CLEAR) && (bad1 || (uses_b && bad2));

   // State register; reset always restarts array initialisation
   always_ff @(posedge clk) begin
      if (!reset) state <= S_INIT;
      else        state <= state_nxt;
   end

   // Next-state sequencing and handshake outputs
   always_comb begin
      state_nxt = state;
      busy      = (state != S_IDLE);
      done      = (state == S_DONE);
      case (state)
         S_INIT:   if (idx == LAST_IDX) state_nxt = clr_pend ? S_DONE : S_IDLE;
         S_IDLE:   if (start) state_nxt = (op == OP_CLEAR) ? S_INIT :
                                          (op_err ? S_DONE : S_FIND_A);
         S_FIND_A: if (cur_par == cur) state_nxt = S_COMP_A;
         S_COMP_A: if (cur == root_a) state_nxt = (op_q == OP_FIND) ? S_DONE : S_FIND_B;
         S_FIND_B: if (cur_par == cur) state_nxt = S_COMP_B;
         S_COMP_B: if (cur == root_b) state_nxt = (op_q == OP_UNION) ? S_LINK : S_DONE;
         S_LINK:   state_nxt = S_DONE;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_INIT;
      endcase
   end

   // Datapath: init sweep, operand capture, root walks, compression writes and linking
   always_ff @(posedge clk) begin
      if (!reset) begin
         idx       <= '0;
         clr_pend  <= 1'b0;
         result    <= '0;
         same_set  <= 1'b0;
         merged    <= 1'b0;
         error     <= 1'b0;
         set_count <= N_SETS;
         op_q      <= OP_FIND;
         n1_q      <= '0;
         n2_q      <= '0;
         cur       <= '0;
         root_a    <= '0;
         root_b    <= '0;
      end else begin
         case (state)
            S_INIT: begin
               parent[idx] <= idx;
               rank[idx]   <= '0;
               if (idx == LAST_IDX) begin
                  idx      <= '0;
                  clr_pend <= 1'b0;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            S_IDLE: if (start) begin
               op_q     <= op;
               n1_q     <= node1;
               n2_q     <= node2;
               cur      <= node1;
               result   <= '0;
               same_set <= 1'b0;
               merged   <= 1'b0;
               error    <= op_err;
               if (op == OP_CLEAR) begin
                  clr_pend  <= 1'b1;
                  set_count <= N_SETS;
                  idx       <= '0;
               end
            end
            S_FIND_A: begin
               if (cur_par == cur) begin
                  root_a <= cur;
                  cur    <= n1_q;
               end else begin
                  cur <= cur_par;
               end
            end
            S_COMP_A: begin
               if (cur == root_a) begin
                  cur <= n2_q;
                  if (op_q == OP_FIND) result <= root_a;
               end else begin
                  parent[cur] <= root_a;
                  cur         <= cur_par;
               end
            end
            S_FIND_B: begin
               if (cur_par == cur) begin
                  root_b <= cur;
                  cur    <= n2_q;
               end else begin
                  cur <= cur_par;
               end
            end
            S_COMP_B: begin
               if (cur == root_b) begin
                  if (op_q == OP_SAME) begin
                     result   <= root_a;
                     same_set <= roots_eq;
                  end
               end else begin
                  parent[cur] <= root_b;
                  cur         <= cur_par;
               end
            end
            S_LINK: begin
               if (roots_eq) begin
                  same_set <= 1'b1;
                  merged   <= 1'b0;
                  result   <= root_a;
               end else begin
                  merged <= 1'b1;
                  if (set_count > (ADDR_WIDTH + 1)'(1)) set_count <= set_count - 1'b1;
                  if (rank_a < rank_b) begin
                     parent[root_a] <= root_b;
                     result         <= root_b;
                  end else begin
                     // rootA also wins ties; its rank grows only on a tie
                     parent[root_b] <= root_a;
                     result         <= root_a;
                     if (rank_a == rank_b && rank_a != RANK_MAX) rank[root_a] <= rank_a + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule
